// File: rtl/core_mem_pkg.sv
// Shared constants for the core memory bridge: MMIO register offsets and STATUS bit positions.
package core_mem_pkg;

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLES = 8'h08;
  localparam logic [7:0] OFF_HALT   = 8'h0C;

  localparam int ST_EMPTY = 2;
  localparam int ST_FULL  = 3;
  localparam int ST_OVF   = 4;

  // Registers are word-addressed; the low two offset bits never take part in decode.
  function automatic logic [5:0] word_off(input logic [7:0] off);
    return off[7:2];
  endfunction

endpackage

// File: rtl/core_tx_fifo.sv
// Byte TX FIFO with a simultaneous push/pop path when full; dout reads 0 while empty.
module core_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clk) begin
    if (resetn && do_push) begin
      store[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_mem_bridge.sv
// Memory-side bridge for the multicycle core: unified RAM plus an MMIO page (TX FIFO, status, halt).
// Optional CYCLE_COUNTER_EN adds a free-running cycle counter readable at offset 0x08.
module core_mem_bridge
  import core_mem_pkg::*;
#(
  parameter int          MEM_WORDS  = 4096,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic          mmio_sel;
  logic [AW-1:0] idx;
  logic [5:0]    reg_sel;
  logic          hit_txdata;
  logic          hit_status;
  logic          hit_halt;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          ovf;
  logic [31:0]   status;
  logic [31:0]   mmio_rd;
  logic [31:0]   cycles;
  logic [1:0]    unused_addr_lsb;

  assign unused_addr_lsb = addr[1:0];

  assign mmio_sel   = (addr[31:8] == MMIO_BASE[31:8]);
  assign idx        = addr[AW+1:2];
  assign reg_sel    = addr[7:2];
  assign hit_txdata = mmio_sel && (reg_sel == word_off(OFF_TXDATA));
  assign hit_status = mmio_sel && (reg_sel == word_off(OFF_STATUS));
  assign hit_halt   = mmio_sel && (reg_sel == word_off(OFF_HALT));

  // RAM is deliberately not reset; reads stay combinational so the core sees data next cycle.
  always_ff @(posedge clk) begin
    if (we && !mmio_sel) begin
      mem[idx] <= wdata;
    end
  end

  assign push     = we && hit_txdata;
  assign pop      = tx_valid && tx_ready;
  assign tx_valid = !fifo_empty;

  core_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (wdata[7:0]),
    .full   (fifo_full),
    .pop    (pop),
    .dout   (tx_data),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf <= 1'b0;
    end else if (we && hit_status) begin
      ovf <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      halt <= 1'b0;
    end else if (we && hit_halt && wdata[0]) begin
      halt <= 1'b1;
    end
  end

`ifdef CYCLE_COUNTER_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end
`else
  assign cycles = '0;
`endif

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = ovf;
  end

  always_comb begin
    mmio_rd = '0;
    if (reg_sel == word_off(OFF_STATUS)) begin
      mmio_rd = status;
    end else if (reg_sel == word_off(OFF_CYCLES)) begin
      mmio_rd = cycles;
    end else if (reg_sel == word_off(OFF_HALT)) begin
      mmio_rd = {31'b0, halt};
    end
  end

  assign rdata = mmio_sel ? mmio_rd : mem[idx];

endmodule

// File: tb/tb_core_mem_bridge.sv
// Self-checking bench for core_mem_bridge: RAM, address wrap, TX FIFO scoreboard, halt and cycle counter.
module tb_core_mem_bridge;

  localparam logic [31:0] A_TXDATA = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h1000_0004;
  localparam logic [31:0] A_CYCLES = 32'h1000_0008;
  localparam logic [31:0] A_HALT   = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;

  int tests_run = 0;
  int fails = 0;
  logic [7:0] exp_q [$];

  core_mem_bridge dut (
    .clk      (clk),
    .resetn   (resetn),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .halt     (halt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; sampling happens well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_accept);
    write_word(A_TXDATA, {24'h0, b});
    if (expect_accept) exp_q.push_back(b);
  endtask

  // Drains with tx_ready=1, comparing each popped byte against the scoreboard.
  task automatic drain(input string name, output int pops, output logic [7:0] last);
    logic [7:0] exp_b;
    pops = 0;
    last = '0;
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_valid; i++) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL %s: popped 0x%02h with no expected byte queued", name, tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (tx_data !== exp_b) begin
          fails++;
          $display("FAIL %s: tx_data=0x%02h expected 0x%02h", name, tx_data, exp_b);
        end
      end
      last = tx_data;
      pops++;
      tick();
    end
    tx_ready = 1'b0;
    tests_run++;
    if (tx_valid !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_end: tx_valid=%b queue_left=%0d expected 0/0", name, tx_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    addr     = '0;
    wdata    = '0;
    we       = 1'b0;
    tx_ready = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    addr   = A_STATUS;
    #1;
    tests_run++;
    if (tx_valid !== 1'b0 || halt !== 1'b0 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: tx_valid=%b halt=%b tx_data=0x%02h expected 0 0 0x00", tx_valid, halt, tx_data);
    end
    tests_run++;
    if (rdata !== 32'h04) begin
      fails++;
      $display("FAIL reset_status: got 0x%08h expected 0x00000004", rdata);
    end
  endtask

  task automatic test_ram();
    write_word(32'h0000_0010, 32'h1111_1111);
    addr  = 32'h0000_0010;
    wdata = 32'hDEAD_BEEF;
    we    = 1'b1;
    #1;
    tests_run++;
    if (rdata !== 32'h1111_1111) begin
      fails++;
      $display("FAIL ram_same_cycle: got 0x%08h expected 0x11111111", rdata);
    end
    tick();
    we = 1'b0;
    tests_run++;
    if (rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL ram_next_cycle: got 0x%08h expected 0xDEADBEEF", rdata);
    end
    addr = 32'h0000_0013;
    #1;
    tests_run++;
    if (rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL ram_byte_offset: got 0x%08h expected 0xDEADBEEF", rdata);
    end
  endtask

  task automatic test_wrap();
    write_word(32'h0000_4004, 32'h0000_1234);
    addr = 32'h0000_0004;
    #1;
    tests_run++;
    if (rdata !== 32'h0000_1234) begin
      fails++;
      $display("FAIL ram_wrap: got 0x%08h expected 0x00001234", rdata);
    end
    write_word(32'h0000_0008, 32'h0000_5678);
    addr = 32'h0000_4008;
    #1;
    tests_run++;
    if (rdata !== 32'h0000_5678) begin
      fails++;
      $display("FAIL ram_wrap_alias: got 0x%08h expected 0x00005678", rdata);
    end
  endtask

  task automatic test_fifo_overflow();
    int pops;
    logic [7:0] last;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'h41 + 8'(i), 1'b1);
    addr = A_STATUS;
    #1;
    tests_run++;
    if (rdata !== 32'h08 || tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      fails++;
      $display("FAIL fifo_full: status=0x%08h tx_valid=%b head=0x%02h expected 0x08 1 0x41", rdata, tx_valid, tx_data);
    end
    push_byte(8'h49, 1'b0);
    addr = A_STATUS;
    #1;
    tests_run++;
    if (rdata !== 32'h18) begin
      fails++;
      $display("FAIL fifo_ovf: status=0x%08h expected 0x18", rdata);
    end
    drain("ovf_drain", pops, last);
    tests_run++;
    if (pops != 8 || last !== 8'h48) begin
      fails++;
      $display("FAIL ovf_drain_count: pops=%0d last=0x%02h expected 8 0x48", pops, last);
    end
    addr = A_STATUS;
    #1;
    tests_run++;
    if (rdata !== 32'h14) begin
      fails++;
      $display("FAIL status_after_drain: got 0x%08h expected 0x14", rdata);
    end
    write_word(A_STATUS, 32'h0);
    addr = A_STATUS;
    #1;
    tests_run++;
    if (rdata !== 32'h04) begin
      fails++;
      $display("FAIL ovf_clear: status=0x%08h expected 0x04", rdata);
    end
  endtask

  task automatic test_full_push_pop();
    int pops;
    logic [7:0] last;
    logic [7:0] exp_b;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'h61 + 8'(i), 1'b1);
    addr     = A_TXDATA;
    wdata    = 32'h55;
    we       = 1'b1;
    tx_ready = 1'b1;
    #1;
    exp_b = exp_q.pop_front();
    tests_run++;
    if (tx_data !== exp_b) begin
      fails++;
      $display("FAIL full_pop_head: tx_data=0x%02h expected 0x%02h", tx_data, exp_b);
    end
    exp_q.push_back(8'h55);
    tick();
    we       = 1'b0;
    tx_ready = 1'b0;
    addr     = A_STATUS;
    #1;
    tests_run++;
    if (rdata !== 32'h08) begin
      fails++;
      $display("FAIL full_push_pop_status: got 0x%08h expected 0x08", rdata);
    end
    drain("pp_drain", pops, last);
    tests_run++;
    if (pops != 8 || last !== 8'h55) begin
      fails++;
      $display("FAIL pp_last_byte: pops=%0d last=0x%02h expected 8 0x55", pops, last);
    end
    addr = A_STATUS;
    #1;
    tests_run++;
    if (rdata !== 32'h04) begin
      fails++;
      $display("FAIL pp_status_end: got 0x%08h expected 0x04", rdata);
    end
  endtask

  task automatic test_halt();
    tests_run++;
    if (halt !== 1'b0) begin
      fails++;
      $display("FAIL halt_initial: halt=%b expected 0", halt);
    end
    write_word(A_HALT, 32'h1);
    addr = A_HALT;
    #1;
    tests_run++;
    if (halt !== 1'b1 || rdata !== 32'h1) begin
      fails++;
      $display("FAIL halt_set: halt=%b rd=0x%08h expected 1 0x1", halt, rdata);
    end
    write_word(A_HALT, 32'h0);
    tests_run++;
    if (halt !== 1'b1) begin
      fails++;
      $display("FAIL halt_sticky: halt=%b expected 1", halt);
    end
    tx_ready = 1'b0;
    push_byte(8'h77, 1'b0);
    addr   = A_TXDATA;
    wdata  = 32'h99;
    we     = 1'b1;
    resetn = 1'b0;
    tick();
    we   = 1'b0;
    addr = 32'h0000_0010;
    #1;
    tests_run++;
    if (rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL ram_during_reset: got 0x%08h expected 0xDEADBEEF", rdata);
    end
    resetn = 1'b1;
    addr   = A_STATUS;
    #1;
    tests_run++;
    if (halt !== 1'b0 || tx_valid !== 1'b0 || rdata !== 32'h04) begin
      fails++;
      $display("FAIL halt_reset: halt=%b tx_valid=%b status=0x%08h expected 0 0 0x04", halt, tx_valid, rdata);
    end
  endtask

  task automatic test_cycles();
    logic [31:0] exp10;
    logic [31:0] exp11;
`ifdef CYCLE_COUNTER_EN
    exp10 = 32'd10;
    exp11 = 32'd11;
`else
    exp10 = 32'd0;
    exp11 = 32'd0;
`endif
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    addr = A_CYCLES;
    #1;
    tests_run++;
    if (rdata !== exp10) begin
      fails++;
      $display("FAIL cycles_10: got %0d expected %0d", rdata, exp10);
    end
    write_word(A_CYCLES, 32'h0);
    addr = A_CYCLES;
    #1;
    tests_run++;
    if (rdata !== exp11) begin
      fails++;
      $display("FAIL cycles_write_ignored: got %0d expected %0d", rdata, exp11);
    end
    addr = 32'h1000_0020;
    #1;
    tests_run++;
    if (rdata !== 32'h0) begin
      fails++;
      $display("FAIL unmapped_read: got 0x%08h expected 0x0", rdata);
    end
    addr = A_TXDATA;
    #1;
    tests_run++;
    if (rdata !== 32'h0) begin
      fails++;
      $display("FAIL txdata_read: got 0x%08h expected 0x0", rdata);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_wrap();
    test_fifo_overflow();
    test_full_push_pop();
    test_halt();
    test_cycles();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
